// File: rtl/bsg_mem_1rw_sync_segmented_req_ctrl.sv
// Credit-gated request front-end for a segmented 1rw sync memory, with a response FIFO.
// Optional write acknowledgements: define BSG_MEM_SEG_REQ_CTRL_WRITE_ACK_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_mem_1rw_sync_segmented_req_ctrl #(
  parameter int width_p        = 32,
  parameter int els_p          = 64,
  parameter int num_segments_p = 4,
  parameter int buf_els_p      = 2,
  localparam int lg_els_lp     = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic                      w_i,
  input  logic [num_segments_p-1:0] seg_en_i,
  input  logic [lg_els_lp-1:0]      addr_i,
  input  logic [width_p-1:0]        data_i,
  input  logic [width_p-1:0]        w_mask_i,
  output logic [num_segments_p-1:0] mem_v_o,
  output logic                      mem_w_o,
  output logic [lg_els_lp-1:0]      mem_addr_o,
  output logic [width_p-1:0]        mem_data_o,
  output logic [width_p-1:0]        mem_w_mask_o,
  input  logic [width_p-1:0]        mem_data_i,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  output logic [num_segments_p-1:0] seg_v_o,
  input  logic                      yumi_i
);

  localparam int seg_w_lp = width_p / num_segments_p;
  localparam int ptr_w_lp = `BSG_SAFE_CLOG2(buf_els_p);
  localparam int cnt_w_lp = $clog2(buf_els_p + 1);
  localparam logic [cnt_w_lp:0] buf_els_lp = (cnt_w_lp + 1)'(buf_els_p);

  logic                      acc, infl_acc;
  logic                      infl_r;
  logic [num_segments_p-1:0] infl_seg_r;
  logic [cnt_w_lp-1:0]       count_r;
  logic [ptr_w_lp-1:0]       rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp:0]         used;
  logic                      push, pop;
  logic [width_p-1:0]        rd_masked, push_data;

  logic [width_p-1:0]        fifo_data [buf_els_p];
  logic [num_segments_p-1:0] fifo_seg  [buf_els_p];

  // Outstanding responses = FIFO entries plus the one request still in the memory.
  assign used    = {1'b0, count_r} + (cnt_w_lp + 1)'(infl_r);
  assign ready_o = ~reset_i & (used < buf_els_lp);
  assign acc     = v_i & ready_o;

  assign mem_v_o      = {num_segments_p{acc}} & seg_en_i;
  assign mem_w_o      = w_i;
  assign mem_addr_o   = addr_i;
  assign mem_data_o   = data_i;
  assign mem_w_mask_o = w_mask_i;

  // Memory outputs for disabled segments are not defined, so force them to zero.
  for (genvar s = 0; s < num_segments_p; s++) begin : g_seg
    assign rd_masked[s*seg_w_lp +: seg_w_lp] =
      infl_seg_r[s] ? mem_data_i[s*seg_w_lp +: seg_w_lp] : '0;
  end

`ifdef BSG_MEM_SEG_REQ_CTRL_WRITE_ACK_EN
  logic infl_w_r;
  assign infl_acc  = acc;
  assign push_data = infl_w_r ? '0 : rd_masked;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       infl_w_r <= 1'b0;
    else if (infl_acc) infl_w_r <= w_i;
  end
`else
  assign infl_acc  = acc & ~w_i;
  assign push_data = rd_masked;
`endif

  assign push = infl_r;
  assign v_o  = (count_r != '0);
  assign pop  = yumi_i & v_o;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(buf_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      infl_r     <= 1'b0;
      infl_seg_r <= '0;
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
    end else begin
      infl_r <= infl_acc;
      if (infl_acc) infl_seg_r <= seg_en_i;
      if (push)     wr_ptr_r   <= ptr_inc(wr_ptr_r);
      if (pop)      rd_ptr_r   <= ptr_inc(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr_r] <= push_data;
      fifo_seg[wr_ptr_r]  <= infl_seg_r;
    end
  end

  // Storage is not reset; gating by v_o keeps outputs at zero whenever the FIFO is empty.
  assign data_o  = v_o ? fifo_data[rd_ptr_r] : '0;
  assign seg_v_o = v_o ? fifo_seg[rd_ptr_r]  : '0;

`ifndef SYNTHESIS
  width_div_a: assert property (@(posedge clk_i) (width_p % num_segments_p) == 0)
    else $error("width_p must be divisible by num_segments_p");
  buf_els_a: assert property (@(posedge clk_i) buf_els_p >= 1)
    else $error("buf_els_p must be >= 1");
  yumi_legal_a: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted without v_o");
  no_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (push & ~pop) |-> (count_r < cnt_w_lp'(buf_els_p)))
    else $error("response FIFO overflow");
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_segmented_req_ctrl.sv
// Randomized scoreboard bench for bsg_mem_1rw_sync_segmented_req_ctrl with a behavioural segmented memory.
module tb_bsg_mem_1rw_sync_segmented_req_ctrl;
  localparam int W = 32, E = 64, NS = 4, B = 2, LG = 6, SW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i, ready_o, w_i;
  logic [NS-1:0] seg_en_i;
  logic [LG-1:0] addr_i;
  logic [W-1:0]  data_i, w_mask_i;
  logic [NS-1:0] mem_v_o;
  logic          mem_w_o;
  logic [LG-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_o, mem_w_mask_o, mem_data_i;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic [NS-1:0] seg_v_o;
  logic          yumi_i;

  always #5 clk_i = ~clk_i;

  bsg_mem_1rw_sync_segmented_req_ctrl #(
    .width_p(W), .els_p(E), .num_segments_p(NS), .buf_els_p(B)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
    .seg_en_i(seg_en_i), .addr_i(addr_i), .data_i(data_i), .w_mask_i(w_mask_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i),
    .v_o(v_o), .data_o(data_o), .seg_v_o(seg_v_o), .yumi_i(yumi_i)
  );

  typedef struct packed { logic [W-1:0] d; logic [NS-1:0] s; } resp_t;

  int       checks = 0, errors = 0;
  resp_t    exp_q[$];
  logic [W-1:0] ref_mem  [E];
  logic [W-1:0] phys_mem [E];
  logic     mem_init = 1'b1;
  int       yumi_mode = 0; // 0 random, 1 hold off, 2 always, 3 single pop then hold off

  // Segmented 1rw sync memory: non-enabled segments return garbage.
  always @(posedge clk_i) begin
    logic [W-1:0] wm, rd;
    wm = '0;
    rd = $urandom;
    for (int s = 0; s < NS; s++)
      if (mem_v_o[s]) begin
        if (mem_w_o) wm[s*SW +: SW] = '1;
        else         rd[s*SW +: SW] = phys_mem[mem_addr_o][s*SW +: SW];
      end
    wm = wm & mem_w_mask_o;
    if (mem_init) begin
      for (int a = 0; a < E; a++) phys_mem[a] <= '0;
      mem_init <= 1'b0;
    end else if (mem_w_o) begin
      phys_mem[mem_addr_o] <= (phys_mem[mem_addr_o] & ~wm) | (mem_data_o & wm);
    end
    mem_data_i <= rd;
  end

  function automatic logic [W-1:0] seg_mask(input logic [NS-1:0] s);
    logic [W-1:0] m;
    for (int i = 0; i < NS; i++) m[i*SW +: SW] = {SW{s[i]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+2, sample at +3, drop v_i after the edge.
  task automatic step(input bit v, input bit w, input logic [NS-1:0] seg, input logic [LG-1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] m, output bit acc);
    v_i = v; w_i = w; seg_en_i = seg; addr_i = a; data_i = d; w_mask_i = m;
    #1;
    chk("ready", ready_o, 32'(exp_q.size() < B));
    acc = v && ready_o;
    if (acc) begin
      chk("mem_v", mem_v_o, seg);
      chk("mem_addr", mem_addr_o, a);
    end else begin
      chk("mem_v_idle", mem_v_o, 0);
    end
    @(posedge clk_i); #1;
    v_i = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, '0, acc);
  endtask

  task automatic req(input bit w, input logic [NS-1:0] seg, input logic [LG-1:0] a,
                     input logic [W-1:0] d, input logic [W-1:0] m,
                     input bit use_exp = 0, input logic [W-1:0] exp_d = '0);
    bit acc;
    int n = 0;
    do begin
      step(1, w, seg, a, d, m, acc);
      n++;
    end while (!acc && n < 64);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 64 cycles");
    end else if (w) begin
      ref_mem[a] = (ref_mem[a] & ~(m & seg_mask(seg))) | (d & m & seg_mask(seg));
`ifdef BSG_MEM_SEG_REQ_CTRL_WRITE_ACK_EN
      exp_q.push_back({{W{1'b0}}, seg});
`endif
    end else begin
      exp_q.push_back({use_exp ? exp_d : (ref_mem[a] & seg_mask(seg)), seg});
    end
  endtask

  task automatic drain();
    int n = 0;
    yumi_mode = 2;
    while ((exp_q.size() != 0 || v_o) && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_v_o", v_o, 0);
  endtask

  // Monitor: chooses yumi_i and checks each popped response against the scoreboard.
  initial begin
    yumi_i = 1'b0;
    forever begin
      @(posedge clk_i); #4;
      if (reset_i) begin
        yumi_i = 1'b0;
      end else begin
        bit    take;
        resp_t r;
        take = (yumi_mode == 0) ? 1'($urandom_range(0, 1)) : (yumi_mode != 1);
        if (v_o && exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got v_o=1 data %h expected no response", data_o);
          take = 1'b0;
        end
        if (v_o && take) begin
          r = exp_q.pop_front();
          chk("resp_data", data_o, r.d);
          chk("resp_seg", seg_v_o, r.s);
          if (yumi_mode == 3) yumi_mode = 1;
        end
        yumi_i = v_o & take;
      end
    end
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    for (int a = 0; a < E; a++) ref_mem[a] = '0;
    reset_i = 1'b1; v_i = 1'b1; w_i = 1'b0; seg_en_i = '1;
    addr_i = '0; data_i = '0; w_mask_i = '0;
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_v_o", v_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_mem_v", mem_v_o, 0);
    chk("rst_seg_v", seg_v_o, 0);
    chk("rst_data", data_o, 0);
    @(posedge clk_i); #2;
    reset_i = 1'b0; v_i = 1'b0;
    #1;
    chk("ready_after_reset", ready_o, 1);
    @(posedge clk_i); #2;

    // Directed: full write/read, latency, partial segments, bit-masked write.
    yumi_mode = 2;
    req(1, 4'b1111, 6'd5, 32'hDEADBEEF, 32'hFFFF_FFFF);
    drain();
    req(0, 4'b1111, 6'd5, '0, '0, 1, 32'hDEADBEEF);
    chk("lat_cycle1_v_o", v_o, 0);
    idle(1);
    chk("lat_cycle2_v_o", v_o, 1);
    req(0, 4'b0101, 6'd5, '0, '0, 1, 32'h00AD00EF);
    req(1, 4'b1111, 6'd5, 32'h12345678, 32'hFFFF0000);
    req(0, 4'b1111, 6'd5, '0, '0, 1, 32'h1234BEEF);
    req(0, 4'b0000, 6'd5, '0, '0, 1, 32'h0);
    drain();

    // Credits: two reads fill buf_els_p, a third waits until one pop is consumed.
    yumi_mode = 1;
    req(0, 4'b1111, 6'd5, '0, '0);
    chk("ready_one_credit", ready_o, 1);
    req(0, 4'b0011, 6'd5, '0, '0);
    chk("ready_full", ready_o, 0);
    step(1, 0, 4'b1111, 6'd7, '0, '0, acc);
    chk("blocked_read", acc, 0);
    step(1, 1, 4'b1111, 6'd7, 32'hA5A5A5A5, '1, acc);
    chk("blocked_write", acc, 0);
    yumi_mode = 3;
    #3;
    chk("no_bypass", ready_o, 0);
    @(posedge clk_i); #2;
    chk("credit_return", ready_o, 1);
    req(0, 4'b1100, 6'd5, '0, '0);
    drain();

    // Reset one cycle after a read is accepted: the read is discarded.
    req(0, 4'b1111, 6'd5, '0, '0);
    reset_i = 1'b1;
    v_i = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_v_o", v_o, 0);
    chk("mid_rst_ready", ready_o, 0);
    chk("mid_rst_mem_v", mem_v_o, 0);
    @(posedge clk_i); #2;
    reset_i = 1'b0;
    v_i = 1'b0;
    #1;
    chk("ready_after_mid_reset", ready_o, 1);
    @(posedge clk_i); #2;
    idle(4);
    chk("no_resp_after_reset", v_o, 0);

`ifdef BSG_MEM_SEG_REQ_CTRL_WRITE_ACK_EN
    req(1, 4'b0011, 6'd10, 32'hCAFEF00D, '1);
    req(0, 4'b1111, 6'd10, '0, '0);
    drain();
`endif

    // Random traffic over a small address window so reads hit prior writes.
    yumi_mode = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 2) idle(1);
      else req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)),
               $urandom, $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
